// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt controller for up to NSRC sources.
//
// Rising edges on src latch into pending bits. An enable register masks them,
// and fixed priority arbitration picks the lowest index. A claim/complete
// handshake lets the core service one interrupt at a time. Source i has
// ID i+1, and ID 0 means "none".
//
// Optional feature macro: IRQ_SYNC_EN
//   defined   - each src passes through a 2-flop synchronizer plus a history
//               flop (pending is set two edges after src is first sampled high)
//   undefined - history flop only, for sources already synchronous to clock
//
// Ports:
//   clock    in   single clock, rising edge
//   reset    in   asynchronous, active-high; clears all state
//   src      in   [NSRC-1:0] raw interrupt lines, rising-edge triggered
//   sel      in   bus select for this block (decoded externally)
//   addr     in   [1:0] word offset: 0 PENDING, 1 ENABLE, 2 CLAIM, 3 COMPLETE
//   w_en     in   write strobe, qualified by sel
//   r_en     in   read strobe, qualified by sel
//   w_data   in   [31:0] write data
//   r_data   out  [31:0] read data, combinational from addr and current state
//   int_req  out  registered interrupt request to the core

module irq_controller #(
    parameter int unsigned NSRC = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            sel,
    input  logic [1:0]      addr,
    input  logic            w_en,
    input  logic            r_en,
    input  logic [31:0]     w_data,
    output logic [31:0]     r_data,
    output logic            int_req
);

    localparam int unsigned IDW = 5;
    localparam int unsigned DW  = 32;

    localparam logic [1:0] A_PENDING  = 2'd0;
    localparam logic [1:0] A_ENABLE   = 2'd1;
    localparam logic [1:0] A_CLAIM    = 2'd2;
    localparam logic [1:0] A_COMPLETE = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_CLAIMED
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [NSRC-1:0]   pending;
    logic [NSRC-1:0]   next_pending;
    logic [NSRC-1:0]   enable;
    logic [NSRC-1:0]   next_enable;
    logic [IDW-1:0]    in_service;
    logic [IDW-1:0]    next_in_service;
    logic              next_int_req;

    logic [NSRC-1:0]   src_hist;
    logic [NSRC-1:0]   src_rise;
    logic [IDW-1:0]    claim_id;
    logic [NSRC-1:0]   claim_mask;
    logic              bus_rd;
    logic              bus_wr;
    logic              claim_hit;
    logic              complete_hit;

    // Upper write-data bits are meaningful only for wide ENABLE writes.
    logic              unused_w_data;
    assign unused_w_data = ^w_data;

    // Source edge detection
`ifdef IRQ_SYNC_EN
    logic [NSRC-1:0] sync1;
    logic [NSRC-1:0] sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            src_hist <= '0;
        end else begin
            sync1    <= src;
            sync2    <= sync1;
            src_hist <= sync2;
        end
    end

    assign src_rise = sync2 & ~src_hist;
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_hist <= '0;
        end else begin
            src_hist <= src;
        end
    end

    assign src_rise = src & ~src_hist;
`endif

    // Fixed-priority arbiter: the lowest enabled pending index wins.
    always_comb begin
        claim_id = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (pending[i] && enable[i]) begin
                claim_id = IDW'(i + 1);
            end
        end
    end

    assign bus_rd = sel & r_en;
    assign bus_wr = sel & w_en;

    assign claim_hit    = bus_rd && (addr == A_CLAIM) && (state == ST_IDLE)
                          && (claim_id != '0);
    assign complete_hit = bus_wr && (addr == A_COMPLETE) && (state == ST_CLAIMED)
                          && (w_data[IDW-1:0] == in_service);

    // The claim clears its own pending bit; a new edge on the same cycle re-sets it.
    assign claim_mask = claim_hit ? (NSRC'(1) << (claim_id - IDW'(1))) : '0;

    // Next-state and register update logic
    always_comb begin
        next_state      = state;
        next_in_service = in_service;
        next_enable     = enable;
        next_pending    = (pending & ~claim_mask) | src_rise;

        if (bus_wr && (addr == A_ENABLE)) begin
            next_enable = w_data[NSRC-1:0];
        end

        unique case (state)
            ST_IDLE: begin
                if (claim_hit) begin
                    next_state      = ST_CLAIMED;
                    next_in_service = claim_id;
                end
            end
            ST_CLAIMED: begin
                if (complete_hit) begin
                    next_state      = ST_IDLE;
                    next_in_service = '0;
                end
            end
            default: begin
                next_state      = ST_IDLE;
                next_in_service = '0;
            end
        endcase

        next_int_req = (next_state == ST_IDLE) && (|(next_pending & next_enable));
    end

    // State register; int_req reflects the post-edge state directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pending    <= '0;
            enable     <= '0;
            in_service <= '0;
            int_req    <= 1'b0;
        end else begin
            state      <= next_state;
            pending    <= next_pending;
            enable     <= next_enable;
            in_service <= next_in_service;
            int_req    <= next_int_req;
        end
    end

    // Read mux: CLAIM reads 0 while an interrupt is in service.
    always_comb begin
        r_data = '0;
        if (sel) begin
            unique case (addr)
                A_PENDING:  r_data = DW'(pending);
                A_ENABLE:   r_data = DW'(enable);
                A_CLAIM:    r_data = (state == ST_IDLE) ? DW'(claim_id) : '0;
                A_COMPLETE: r_data = '0;
                default:    r_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: directed handshake scenarios followed by
// randomized bus/source traffic, all checked against a behavioural model.
module tb_irq_controller;

    localparam int unsigned NSRC = 8;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [NSRC-1:0] src;
    logic            sel;
    logic [1:0]      addr;
    logic            w_en;
    logic            r_en;
    logic [31:0]     w_data;
    logic [31:0]     r_data;
    logic            int_req;

    always #5 clock = ~clock;

    irq_controller #(.NSRC(NSRC)) dut (
        .clock   (clock),
        .reset   (reset),
        .src     (src),
        .sel     (sel),
        .addr    (addr),
        .w_en    (w_en),
        .r_en    (r_en),
        .w_data  (w_data),
        .r_data  (r_data),
        .int_req (int_req)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: pending/enable sets, the serviced ID (0 = idle) and
    // a short history of sampled src values for edge detection with latency.
    logic [NSRC-1:0] m_pend;
    logic [NSRC-1:0] m_en;
    int              m_svc;
    logic [NSRC-1:0] m_hist [0:3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_claim_id();
        for (int i = 0; i < int'(NSRC); i++) begin
            if (m_pend[i] && m_en[i]) return i + 1;
        end
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_pend);
            2'd1:    return 32'(m_en);
            2'd2:    return (m_svc == 0) ? 32'(m_claim_id()) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_pend = '0;
        m_en   = '0;
        m_svc  = 0;
        for (int i = 0; i < 4; i++) m_hist[i] = '0;
    endtask

    // One bus cycle: drive at negedge, check r_data before the edge,
    // advance the model, check int_req just after the edge.
    task automatic cycle(input logic [NSRC-1:0] s, input logic se, input logic [1:0] a,
                         input logic we, input logic re, input logic [31:0] wd,
                         output logic [31:0] rd);
        int              id;
        logic [NSRC-1:0] rise;
        @(negedge clock);
        src = s; sel = se; addr = a; w_en = we; r_en = re; w_data = wd;
        #1;
        rd = r_data;
        check("r_data", r_data, se ? m_read(a) : 32'd0);

        id = m_claim_id();
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = s;
        rise = m_hist[LAT] & ~m_hist[LAT+1];
        if (se && re && a == 2'd2 && m_svc == 0 && id != 0) begin
            m_pend[id-1] = 1'b0;
            m_svc = id;
        end else if (se && we && a == 2'd3 && m_svc != 0 && int'(wd[4:0]) == m_svc) begin
            m_svc = 0;
        end
        if (se && we && a == 2'd1) m_en = wd[NSRC-1:0];
        m_pend = m_pend | rise;

        @(posedge clock);
        #1;
        check("int_req", 32'(int_req), 32'((m_svc == 0) && (|(m_pend & m_en))));
    endtask

    task automatic idle(input logic [NSRC-1:0] s);
        logic [31:0] rd;
        cycle(s, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, rd);
    endtask

    task automatic rd_reg(input logic [NSRC-1:0] s, input logic [1:0] a, output logic [31:0] rd);
        cycle(s, 1'b1, a, 1'b0, 1'b1, 32'd0, rd);
    endtask

    task automatic wr_reg(input logic [NSRC-1:0] s, input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        cycle(s, 1'b1, a, 1'b1, 1'b0, wd, rd);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        src = '0; sel = 1'b0; addr = 2'd0; w_en = 1'b0; r_en = 1'b0; w_data = '0;
        #1;
        check("rst_int_req", 32'(int_req), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_reset();
    endtask

    initial begin
        logic [31:0]     rd;
        logic [NSRC-1:0] rs;
        logic [1:0]      ra;
        logic            rse, rwe, rre;
        logic [31:0]     rwd;

        reset = 1'b1;
        src = '0; sel = 1'b0; addr = 2'd0; w_en = 1'b0; r_en = 1'b0; w_data = '0;
        m_reset();
        repeat (2) @(posedge clock);
        do_reset();

        // Reset then idle: all registers read 0; a disabled edge still latches.
        for (int a = 0; a < 4; a++) begin
            rd_reg('0, 2'(a), rd);
            check("reset_read", rd, 32'd0);
        end
        check("reset_int_req", 32'(int_req), 32'd0);
        for (int j = 0; j < LAT + 2; j++) idle(8'h08);
        rd_reg(8'h08, 2'd0, rd);
        check("disabled_pending", rd, 32'h08);
        check("disabled_no_irq", 32'(int_req), 32'd0);

        // Two sources together: priority, claim, complete, next claim.
        do_reset();
        wr_reg('0, 2'd1, 32'hFF);
        idle(8'h24);
        for (int j = 0; j < LAT + 1; j++) idle('0);
        check("irq_raised", 32'(int_req), 32'd1);
        rd_reg('0, 2'd2, rd);
        check("claim_3", rd, 32'd3);
        check("irq_drop_claim", 32'(int_req), 32'd0);
        rd_reg('0, 2'd0, rd);
        check("pending_after_claim", rd, 32'h20);
        wr_reg('0, 2'd3, 32'd5);
        rd_reg('0, 2'd2, rd);
        check("claim_in_service", rd, 32'd0);
        check("wrong_complete_irq", 32'(int_req), 32'd0);
        wr_reg('0, 2'd3, 32'd3);
        check("irq_after_complete", 32'(int_req), 32'd1);
        rd_reg('0, 2'd2, rd);
        check("claim_6", rd, 32'd6);
        wr_reg('0, 2'd3, 32'd6);
        check("all_done_irq", 32'(int_req), 32'd0);

        // src[0] edge lands on the edge that claims ID 1: the set wins.
        do_reset();
        wr_reg('0, 2'd1, 32'hFF);
        idle(8'h01);
        for (int j = 0; j < LAT + 3; j++) idle('0);
        for (int j = 0; j <= LAT; j++) begin
            cycle(8'h01, j == LAT, 2'd2, 1'b0, j == LAT, 32'd0, rd);
        end
        check("claim_1", rd, 32'd1);
        rd_reg(8'h01, 2'd0, rd);
        check("set_wins", rd, 32'h01);
        wr_reg('0, 2'd3, 32'd1);
        check("reassert", 32'(int_req), 32'd1);

        // A held level produces exactly one pending event, after LAT edges.
        do_reset();
        for (int j = 0; j < 10; j++) begin
            rd_reg(8'h10, 2'd0, rd);
            check("level_latency", rd, (j > LAT) ? 32'h10 : 32'h0);
        end
        idle('0);
        wr_reg('0, 2'd1, 32'h10);
        rd_reg('0, 2'd2, rd);
        check("claim_5", rd, 32'd5);
        wr_reg('0, 2'd3, 32'd5);
        rd_reg('0, 2'd0, rd);
        check("single_event", rd, 32'h0);

        // Asynchronous reset while CLAIMED with pending = 0x11.
        do_reset();
        wr_reg('0, 2'd1, 32'hFF);
        idle(8'h02);
        for (int j = 0; j < LAT + 1; j++) idle('0);
        rd_reg('0, 2'd2, rd);
        check("claim_2", rd, 32'd2);
        idle(8'h11);
        for (int j = 0; j < LAT + 1; j++) idle('0);
        rd_reg('0, 2'd0, rd);
        check("pending_11", rd, 32'h11);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_int_req", 32'(int_req), 32'd0);
        for (int a = 0; a < 4; a++) begin
            sel = 1'b1; r_en = 1'b1; addr = 2'(a);
            #1;
            check("async_read", r_data, 32'd0);
        end
        sel = 1'b0; r_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        m_reset();
        rd_reg('0, 2'd2, rd);
        check("post_reset_claim", rd, 32'd0);

        // Randomized traffic against the model.
        do_reset();
        rs = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < int'(NSRC); b++) begin
                if ($urandom_range(0, 7) == 0) rs[b] = ~rs[b];
            end
            rse = ($urandom_range(0, 3) != 0);
            ra  = 2'($urandom_range(0, 3));
            rwe = 1'($urandom_range(0, 1));
            rre = 1'($urandom_range(0, 1));
            rwd = $urandom;
            if (ra == 2'd3 && $urandom_range(0, 2) != 0) rwd = 32'(m_svc);
            cycle(rs, rse, ra, rwe, rre, rwd, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
